// File: rtl/la_oai221_bist_if.sv
// Control/status and cell-side bundle for the oai221 BIST sequencer.
// Signals: start, vec, z_in, busy, done, pass, err_count, fail_valid, fail_vec, signature.
interface la_oai221_bist_if #(
  parameter int ERRW = 6
);
  logic            start;
  logic [4:0]      vec;
  logic            z_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] err_count;
  logic            fail_valid;
  logic [4:0]      fail_vec;
  logic [15:0]     signature;

  modport master (
    output start,
    output z_in,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_vec,
    input  signature
  );

  modport slave (
    input  start,
    input  z_in,
    output vec,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_vec,
    output signature
  );
endinterface

// File: rtl/la_oai221_bist.sv
// BIST sequencer screening one oai221 cell: z = ~((a0|a1)&(b0|b1)&c0).
// Ports: clk, reset (sync, active-high), bus (slave): start/vec/z_in in/out,
//   busy/done/pass/err_count/fail_valid/fail_vec/signature status.
// Optional: LA_OAI221_BIST_MISR_EN adds a 16-bit MISR over sampled z_in.
module la_oai221_bist #(
  parameter string PROP   = "DEFAULT",
  parameter int    SETTLE = 2,
  parameter int    ERRW   = 6
) (
  input  logic              clk,
  input  logic              reset,
  la_oai221_bist_if.slave   bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] WLAST =
    (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [4:0]      idx;
  logic [CW-1:0]   wcnt;
  logic [4:0]      vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [ERRW-1:0] err_q;
  logic            fv_q;
  logic [4:0]      fvec_q;

  logic golden;
  logic mism;
  logic sat;
  logic accept;

  assign golden = ~((vec_q[0] | vec_q[1]) &
                    (vec_q[2] | vec_q[3]) &
                    vec_q[4]);
  assign mism   = bus.z_in != golden;
  assign sat    = &err_q;
  assign accept = bus.start &&
                  (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      wcnt   <= '0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fvec_q <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state  <= S_APPLY;
            idx    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fv_q   <= 1'b0;
            fvec_q <= '0;
          end
        end
        S_APPLY: begin
          vec_q <= idx;
          wcnt  <= '0;
          state <= (SETTLE == 0) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WLAST) begin
            state <= S_CHECK;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (mism) begin
            if (!sat) err_q <= err_q + 1'b1;
            if (!fv_q) begin
              fv_q   <= 1'b1;
              fvec_q <= vec_q;
            end
          end
          if (idx == 5'd31) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // final mismatch counts too
            pass_q <= !(fv_q || mism);
          end else begin
            idx   <= idx + 5'd1;
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;

`ifdef LA_OAI221_BIST_MISR_EN
  logic [15:0] sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= 16'hFFFF;
    end else if (state == S_CHECK) begin
      sig_q <= {sig_q[14:0], 1'b0} ^
               ((sig_q[15] ^ bus.z_in) ? 16'h1021 : 16'h0);
    end
  end

  assign bus.signature = sig_q;
`else
  assign bus.signature = 16'h0;
`endif

endmodule

// File: tb/tb_la_oai221_bist.sv
// Directed bench for la_oai221_bist: good cell, stuck-at faults,
// counter saturation, mid-run reset, start while busy and restart.
module tb_la_oai221_bist;

  logic clk;
  logic reset;
  int   mode;
  int   n_vec;
  int   n_mis;
  int   cyc;

  la_oai221_bist_if #(.ERRW(6)) bus ();
  la_oai221_bist_if #(.ERRW(3)) bus3 ();

  la_oai221_bist #(
    .SETTLE(2),
    .ERRW(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  la_oai221_bist #(
    .SETTLE(2),
    .ERRW(3)
  ) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: good cell, 1: stuck-at-0, 2: stuck-at-1
  assign bus.z_in =
    (mode == 1) ? 1'b0 :
    (mode == 2) ? 1'b1 :
    ~((bus.vec[0] | bus.vec[1]) &
      (bus.vec[2] | bus.vec[3]) & bus.vec[4]);
  assign bus3.z_in  = 1'b0;
  assign bus3.start = bus.start;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [15:0] misr_model();
    logic [15:0] s;
    logic [4:0]  v;
    logic        z;
    s = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      z = ~((v[0] | v[1]) & (v[2] | v[3]) & v[4]);
      s = {s[14:0], 1'b0} ^ ((s[15] ^ z) ? 16'h1021 : 16'h0);
    end
    return s;
  endfunction

  initial begin
    n_vec     = 0;
    n_mis     = 0;
    mode      = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_vec", 32'(bus.vec), 0);
    check("rst_err", 32'(bus.err_count), 0);
    check("rst_fv", 32'(bus.fail_valid), 0);
    check("rst_sig", 32'(bus.signature), 0);
    reset = 1'b0;

    // 1: good cell
    pulse_start;
    check("t1_busy", 32'(bus.busy), 1);
    wait_done(cyc);
    check("t1_lat", 32'(cyc), 128);
    check("t1_busy_end", 32'(bus.busy), 0);
    check("t1_pass", 32'(bus.pass), 1);
    check("t1_err", 32'(bus.err_count), 0);
    check("t1_fv", 32'(bus.fail_valid), 0);
    check("t1_vec", 32'(bus.vec), 31);
`ifdef LA_OAI221_BIST_MISR_EN
    check("t1_sig", 32'(bus.signature), 32'(misr_model()));
`else
    check("t1_sig", 32'(bus.signature), 0);
`endif
    // 4: ERRW=3 copy saw stuck-at-0 on the same run
    check("t4_done", 32'(bus3.done), 1);
    check("t4_err", 32'(bus3.err_count), 7);
    check("t4_pass", 32'(bus3.pass), 0);
    check("t4_fvec", 32'(bus3.fail_vec), 0);

    // 2: stuck-at-0
    mode = 1;
    pulse_start;
    wait_done(cyc);
    check("t2_lat", 32'(cyc), 128);
    check("t2_err", 32'(bus.err_count), 23);
    check("t2_fvec", 32'(bus.fail_vec), 0);
    check("t2_fv", 32'(bus.fail_valid), 1);
    check("t2_pass", 32'(bus.pass), 0);

    // 3: stuck-at-1
    mode = 2;
    pulse_start;
    wait_done(cyc);
    check("t3_err", 32'(bus.err_count), 9);
    check("t3_fvec", 32'(bus.fail_vec), 21);
    check("t3_pass", 32'(bus.pass), 0);

    // 5: reset mid-run at vec==10
    mode = 1;
    pulse_start;
    cyc = 0;
    while (bus.vec != 5'd10 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t5_reach", 32'(bus.vec), 10);
    check("t5_err_pre", 32'(bus.err_count != 0), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_done", 32'(bus.done), 0);
    check("t5_vec", 32'(bus.vec), 0);
    check("t5_err", 32'(bus.err_count), 0);
    mode = 0;
    pulse_start;
    wait_done(cyc);
    check("t5_lat", 32'(cyc), 128);
    check("t5_pass", 32'(bus.pass), 1);

    // 6: start while busy is ignored
    pulse_start;
    repeat (49) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("t6_busy_mid", 32'(bus.busy), 1);
    wait_done(cyc);
    check("t6_lat", 32'(cyc + 50), 128);

    // 6b: restart from DONE clears results
    mode = 2;
    pulse_start;
    wait_done(cyc);
    check("t6_err9", 32'(bus.err_count), 9);
    mode = 0;
    pulse_start;
    check("t6_done_clr", 32'(bus.done), 0);
    check("t6_err_clr", 32'(bus.err_count), 0);
    check("t6_fv_clr", 32'(bus.fail_valid), 0);
    check("t6_busy", 32'(bus.busy), 1);
    wait_done(cyc);
    check("t6_lat2", 32'(cyc), 128);
    check("t6_pass", 32'(bus.pass), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
